// File: rtl/mux4x2_rr_sched.sv
// Round-robin 4-to-2 lane scheduler: grants up to two valid lanes per cycle onto registered out0/out1.
// Optional per-lane saturating grant counters are enabled with `define MUX4X2_SCHED_STATS_EN.
module mux4x2_rr_sched #(
    parameter int BW    = 8,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BW:0]   in0,
    input  logic [BW:0]   in1,
    input  logic [BW:0]   in2,
    input  logic [BW:0]   in3,
    output logic [3:0]    ready,
    output logic [BW:0]   out0,
    output logic [BW:0]   out1,
    output logic [1:0]    gnt0_idx,
    output logic [1:0]    gnt1_idx,
    output logic          active
`ifdef MUX4X2_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
    output logic [CNT_W-1:0] gnt_cnt2,
    output logic [CNT_W-1:0] gnt_cnt3
`endif
);

    logic [BW:0]  lane_w_s [4];
    logic [3:0]   vld_s;
    logic [1:0]   ptr_r;
    logic [1:0]   lane_s;
    logic [1:0]   sel0_s;
    logic [1:0]   sel1_s;
    logic         has0_s;
    logic         has1_s;
    logic [3:0]   grant_s;
    logic [1:0]   ptr_nxt_s;
    logic [BW:0]  out0_nxt_s;
    logic [BW:0]  out1_nxt_s;
    logic [BW:0]  out0_r;
    logic [BW:0]  out1_r;
    logic [1:0]   gnt0_idx_r;
    logic [1:0]   gnt1_idx_r;
    logic         active_r;

    // Gather lane words into an indexable array and extract the valid bits.
    always_comb begin
        lane_w_s[0] = in0;
        lane_w_s[1] = in1;
        lane_w_s[2] = in2;
        lane_w_s[3] = in3;
        vld_s = {in3[BW], in2[BW], in1[BW], in0[BW]};
    end

    // Scan lanes starting at ptr; first valid lane takes slot 0, second takes slot 1.
    always_comb begin
        sel0_s = 2'd0;
        sel1_s = 2'd0;
        has0_s = 1'b0;
        has1_s = 1'b0;
        lane_s = 2'd0;
        for (int k = 0; k < 4; k++) begin
            lane_s = ptr_r + 2'(k);
            if (vld_s[lane_s] && !has0_s) begin
                has0_s = 1'b1;
                sel0_s = lane_s;
            end else if (vld_s[lane_s] && !has1_s) begin
                has1_s = 1'b1;
                sel1_s = lane_s;
            end else begin
                has1_s = has1_s;
            end
        end
    end

    // Grant vector, next-state pointer and next output words.
    always_comb begin
        grant_s = 4'b0000;
        if (has0_s) begin
            grant_s[sel0_s] = 1'b1;
        end else begin
            grant_s = 4'b0000;
        end
        if (has1_s) begin
            grant_s[sel1_s] = 1'b1;
        end else begin
            grant_s = grant_s;
        end
        if (has1_s) begin
            ptr_nxt_s = sel1_s + 2'd1;
        end else if (has0_s) begin
            ptr_nxt_s = sel0_s + 2'd1;
        end else begin
            ptr_nxt_s = ptr_r;
        end
        out0_nxt_s = has0_s ? {1'b1, lane_w_s[sel0_s][BW-1:0]} : {(BW+1){1'b0}};
        out1_nxt_s = has1_s ? {1'b1, lane_w_s[sel1_s][BW-1:0]} : {(BW+1){1'b0}};
    end

    // Ready is suppressed while reset is asserted so no word is consumed.
    assign ready = reset ? grant_s : 4'b0000;

    // Pointer and registered output slots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r      <= 2'd0;
            out0_r     <= {(BW+1){1'b0}};
            out1_r     <= {(BW+1){1'b0}};
            gnt0_idx_r <= 2'd0;
            gnt1_idx_r <= 2'd0;
            active_r   <= 1'b0;
        end else begin
            ptr_r      <= ptr_nxt_s;
            out0_r     <= out0_nxt_s;
            out1_r     <= out1_nxt_s;
            gnt0_idx_r <= has0_s ? sel0_s : 2'd0;
            gnt1_idx_r <= has1_s ? sel1_s : 2'd0;
            active_r   <= has0_s | has1_s;
        end
    end

    assign out0     = out0_r;
    assign out1     = out1_r;
    assign gnt0_idx = gnt0_idx_r;
    assign gnt1_idx = gnt1_idx_r;
    assign active   = active_r;

`ifdef MUX4X2_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt_r [4];

    // Per-lane grant counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (grant_s[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    assign gnt_cnt0 = cnt_r[0];
    assign gnt_cnt1 = cnt_r[1];
    assign gnt_cnt2 = cnt_r[2];
    assign gnt_cnt3 = cnt_r[3];
`endif

endmodule
